spi_slave_sequencer: RTL

SPI_SLAVE_SEQUENCER -- requirements
Module: spi_slave_sequencer

---
 rtl/spi_slave_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_sequencer.sv
// rtl/spi_slave_sequencer.sv - double-buffered word sequencer between system words and an SPI slave byte driver
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   signal_cycle      computational-cycle boundary, requests a bank swap
//   signal_wr,data_in push a system word into the next tx staging slot
//   signal_oe         pop the next rx staging word onto data_out
//   data_out          registered received word
//   flag_start/stop   one-cycle frame start / end pulses
//   cs                SPI chip select (active-low, asynchronous)
//   spi_ready         byte-exchanged pulse from the SPI driver
//   spi_rx_byte       byte received, valid with spi_ready
//   spi_tx_byte       byte the driver shifts out next
module spi_slave_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int WORDS          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signal_cycle,
    input  logic                      signal_wr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      signal_oe,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      flag_start,
    output logic                      flag_stop,
    input  logic                      cs,
    input  logic                      spi_ready,
    input  logic [SPI_DATA_WIDTH-1:0] spi_rx_byte,
    output logic [SPI_DATA_WIDTH-1:0] spi_tx_byte
);

    localparam int BPW = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int FL  = WORDS * BPW;
    localparam int BCW = $clog2(FL + 1);
    localparam int WIW = $clog2(WORDS + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]            state;
    logic                  cs_meta;
    logic                  cs_s;
    logic [1:0]            sync_vld;
    logic                  armed;
    logic [BCW-1:0]        bc;
    logic [BCW-1:0]        bc_inc;
    logic [WIW-1:0]        wi;
    logic [WIW-1:0]        ri;
    logic                  swap_pending;

    logic [DATA_WIDTH-1:0] tx_stage      [WORDS];
    logic [DATA_WIDTH-1:0] tx_active     [WORDS];
    logic [DATA_WIDTH-1:0] rx_active     [WORDS];
    logic [DATA_WIDTH-1:0] rx_stage      [WORDS];
    logic [DATA_WIDTH-1:0] tx_stage_nxt  [WORDS];
    logic [DATA_WIDTH-1:0] rx_active_nxt [WORDS];

    logic                  start_frame;
    logic                  end_frame;
    logic                  byte_take;
    logic                  do_swap;
    logic [SPI_DATA_WIDTH-1:0] tx_first;
    logic [SPI_DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rd_word;

    // Byte idx lives in word idx/BPW, MSB byte first within the word.
    function automatic logic [SPI_DATA_WIDTH-1:0] tx_byte_at(input logic [BCW-1:0] idx);
        logic [SPI_DATA_WIDTH-1:0] r;
        r = '0;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < BPW; b++) begin
                if (idx == BCW'(w * BPW + BPW - 1 - b)) begin
                    r = tx_active[w][b*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        // armed is only set once a genuine (post-reset) high cs_s has been seen,
        // so a cs held low through reset cannot fake a falling edge.
        start_frame = (state == IDLE) && armed && !cs_s;
        end_frame   = (state == ACTIVE) && cs_s;
        byte_take   = (state == ACTIVE) && spi_ready && (bc < BCW'(FL));
        // A cycle request landing on the start cycle is deferred to frame end
        // so the frame never mixes old and new tx_active contents.
        do_swap     = ((state == IDLE) && signal_cycle && !start_frame) ||
                      (end_frame && (swap_pending || signal_cycle));
        bc_inc      = bc + BCW'(1);
        tx_first    = tx_byte_at('0);
        tx_next     = tx_byte_at(bc_inc);

        tx_stage_nxt = tx_stage;
        if (signal_wr) begin
            for (int i = 0; i < WORDS; i++) begin
                if (wi == WIW'(i)) tx_stage_nxt[i] = data_in;
            end
        end

        rx_active_nxt = rx_active;
        if (byte_take) begin
            for (int w = 0; w < WORDS; w++) begin
                for (int b = 0; b < BPW; b++) begin
                    if (bc == BCW'(w * BPW + BPW - 1 - b)) begin
                        rx_active_nxt[w][b*SPI_DATA_WIDTH +: SPI_DATA_WIDTH] = spi_rx_byte;
                    end
                end
            end
        end

        rd_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (ri == WIW'(i)) rd_word = rx_stage[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cs_meta      <= 1'b1;
            cs_s         <= 1'b1;
            sync_vld     <= '0;
            armed        <= 1'b0;
            bc           <= '0;
            wi           <= '0;
            ri           <= '0;
            swap_pending <= 1'b0;
            data_out     <= '0;
            flag_start   <= 1'b0;
            flag_stop    <= 1'b0;
            spi_tx_byte  <= '0;
            for (int i = 0; i < WORDS; i++) begin
                tx_stage[i]  <= '0;
                tx_active[i] <= '0;
                rx_active[i] <= '0;
                rx_stage[i]  <= '0;
            end
        end else begin
            cs_meta  <= cs;
            cs_s     <= cs_meta;
            sync_vld <= {sync_vld[0], 1'b1};

            if (start_frame)               armed <= 1'b0;
            else if (sync_vld[1] && cs_s)  armed <= 1'b1;

            flag_start <= start_frame;
            flag_stop  <= end_frame;

            if (start_frame)    state <= ACTIVE;
            else if (end_frame) state <= IDLE;

            if (start_frame)    bc <= '0;
            else if (byte_take) bc <= bc_inc;

            if (start_frame)                           spi_tx_byte <= tx_first;
            else if (byte_take)                        spi_tx_byte <= tx_next;
            else if ((state == ACTIVE) && spi_ready)   spi_tx_byte <= '0;

            if (do_swap)
                swap_pending <= 1'b0;
            else if (signal_cycle && ((state == ACTIVE) || start_frame))
                swap_pending <= 1'b1;

            tx_stage  <= tx_stage_nxt;
            rx_active <= rx_active_nxt;
            if (do_swap) begin
                tx_active <= tx_stage_nxt;
                rx_stage  <= rx_active_nxt;
            end

            if (do_swap)                                  wi <= '0;
            else if (signal_wr && (wi != WIW'(WORDS)))    wi <= wi + WIW'(1);

            if (signal_oe) data_out <= rd_word;
            if (do_swap)                                  ri <= '0;
            else if (signal_oe && (ri != WIW'(WORDS)))    ri <= ri + WIW'(1);
        end
    end

endmodule
